// File: rtl/vga_sram_arbiter.sv
// -----------------------------------------------------------------------------
// vga_sram_arbiter
//
// Shares one external asynchronous 16-bit SRAM (the framebuffer) between the
// display read path and a pixel writer. Display reads always win; writes are
// only taken when no read is requested, which in practice means blanking.
// The block owns every SRAM control pin and inserts one turnaround cycle
// (WR_SETUP) between a read and the following write pulse.
//
// Ports
//   clk            system clock (vga_clk domain)
//   reset_n        asynchronous active-low reset
//   rd_req         display read request, held until accepted
//   rd_addr        read word address, valid with rd_req
//   rd_ready       read accepted this cycle when rd_req & rd_ready
//   rd_data        read data, valid with rd_valid
//   rd_valid       one-cycle strobe per accepted read (2 cycles after accept)
//   wr_valid       write request, held until accepted
//   wr_addr        write word address
//   wr_data        write data
//   wr_ready       write accepted when wr_valid & wr_ready
//   sram_addr      registered SRAM address
//   sram_data_o    registered SRAM write data
//   sram_data_oe   pad drive enable for sram_data_o
//   sram_data_i    SRAM read data from the pads
//   sram_we_n      SRAM write enable, active low
//   sram_oe_n      SRAM output enable, active low
//   sram_ce_n      SRAM chip enable, active low
//   wr_stall_cnt   (VGA_SRAM_ARB_STATS_EN only) saturating count of cycles a
//                  pending write has been refused since its last acceptance
//
// Optional build macro: VGA_SRAM_ARB_STATS_EN adds the wr_stall_cnt output.
//
// State table
//   state       | meaning
//   ST_IDLE     | bus idle, decision state
//   ST_READ     | read address on the bus with oe_n low, decision state
//   ST_WR_SETUP | write address/data stable, bus turnaround (oe_n=1, oe=0)
//   ST_WR_PULSE | pads driven, we_n low for one cycle
// -----------------------------------------------------------------------------
module vga_sram_arbiter #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,

  input  logic                  wr_valid,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,

  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_data_o,
  output logic                  sram_data_oe,
  input  logic [DATA_WIDTH-1:0] sram_data_i,
  output logic                  sram_we_n,
  output logic                  sram_oe_n,
  output logic                  sram_ce_n
`ifdef VGA_SRAM_ARB_STATS_EN
  ,
  output logic [15:0]           wr_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_READ     = 2'd1,
    ST_WR_SETUP = 2'd2,
    ST_WR_PULSE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_data_oe;
  logic                  r_we_n;
  logic                  r_oe_n;
  logic                  r_ce_n;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;

  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [DATA_WIDTH-1:0] w_wdata_nxt;
  logic                  w_data_oe_nxt;
  logic                  w_we_n_nxt;
  logic                  w_oe_n_nxt;

  logic                  w_decision;
  logic                  w_rd_accept;
  logic                  w_wr_accept;

  // IDLE and READ can both take a new request, so back-to-back reads run
  // at one per cycle without passing through IDLE.
  assign w_decision  = (r_state == ST_IDLE) || (r_state == ST_READ);
  assign w_rd_accept = w_decision & rd_req;
  assign w_wr_accept = w_decision & ~rd_req & wr_valid;

  assign rd_ready = w_decision;
  assign wr_ready = w_decision & ~rd_req;

  // ---------------------------------------------------------------------------
  // Next-state and next-pin logic. The SRAM pins are registered, so each
  // state's pin values are produced here one cycle ahead, on the transition
  // into that state.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_oe_n_nxt    = 1'b1;
    w_we_n_nxt    = 1'b1;
    w_data_oe_nxt = 1'b0;

    case (r_state)
      ST_IDLE,
      ST_READ: begin
        if (w_rd_accept) begin
          w_state_nxt = ST_READ;
          w_addr_nxt  = rd_addr;
          w_oe_n_nxt  = 1'b0;
        end else if (w_wr_accept) begin
          w_state_nxt = ST_WR_SETUP;
          w_addr_nxt  = wr_addr;
          w_wdata_nxt = wr_data;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_WR_SETUP: begin
        // oe_n went high on entry to WR_SETUP, so the SRAM has released
        // the bus by the time the pads are driven here.
        w_state_nxt   = ST_WR_PULSE;
        w_we_n_nxt    = 1'b0;
        w_data_oe_nxt = 1'b1;
      end

      ST_WR_PULSE: begin
        // we_n and the pad enable drop together on the same edge.
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Control pins reset asynchronously so a reset during WR_PULSE releases
  // we_n and the pads without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_data_oe <= 1'b0;
      r_we_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_ce_n    <= 1'b1;
    end else begin
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_data_oe <= w_data_oe_nxt;
      r_we_n    <= w_we_n_nxt;
      r_oe_n    <= w_oe_n_nxt;
      r_ce_n    <= 1'b0;
    end
  end

  // Read capture: the pads are sampled at the end of the READ cycle, giving
  // a two-cycle accept-to-valid latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= (r_state == ST_READ);
      if (r_state == ST_READ) begin
        r_rd_data <= sram_data_i;
      end
    end
  end

  assign sram_addr    = r_addr;
  assign sram_data_o  = r_wdata;
  assign sram_data_oe = r_data_oe;
  assign sram_we_n    = r_we_n;
  assign sram_oe_n    = r_oe_n;
  assign sram_ce_n    = r_ce_n;
  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;

`ifdef VGA_SRAM_ARB_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= 16'd0;
    end else if (w_wr_accept) begin
      r_stall_cnt <= 16'd0;
    end else if (wr_valid && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign wr_stall_cnt = r_stall_cnt;
`endif

endmodule
